mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 112 +++++++++++
 tb/tb_mul_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters.
// Define MUL_ARB_PERF_EN to build the issue_cnt performance counter.

package flexka_pkg;
  localparam int unsigned FSIZE              = 8;
  localparam int unsigned MULTIPLIER_LATENCY = 3;
endpackage

module mul_arbiter
  import flexka_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                              CLK,
  input  logic                              RSTN,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][FSIZE-1:0]     req_a,
  input  logic [NUM_REQ-1:0][FSIZE-1:0]     req_b,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [FSIZE-1:0]                  mul_a,
  output logic [FSIZE-1:0]                  mul_b,
  input  logic [2*FSIZE-1:0]                mul_p,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [2*FSIZE-1:0]                rsp_p,
  output logic [31:0]                       issue_cnt
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LAT = MULTIPLIER_LATENCY;

  logic [IDW-1:0]          ptr_q;
  logic                    grant_vld_c;
  logic [IDW-1:0]          grant_id_c;
  logic [LAT-1:0]          tag_v_q;
  logic [LAT-1:0][IDW-1:0] tag_id_q;

  // First asserted request at or above the pointer, wrapping; nothing granted in reset
  always_comb begin
    grant_vld_c = 1'b0;
    grant_id_c  = ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (RSTN && !grant_vld_c && req_valid[IDW'(idx)]) begin
        grant_vld_c = 1'b1;
        grant_id_c  = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    if (grant_vld_c) begin
      req_ready[grant_id_c] = 1'b1;
      mul_a                 = req_a[grant_id_c];
      mul_b                 = req_b[grant_id_c];
    end
  end

  // A grant always coincides with valid, so every grant is a transfer
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ptr_q <= '0;
    end else if (grant_vld_c) begin
      ptr_q <= (grant_id_c == IDW'(NUM_REQ - 1)) ? '0 : grant_id_c + IDW'(1);
    end
  end

  // Tag pipeline mirrors the multiplier latency; reset drops in-flight results
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      tag_v_q[0]  <= grant_vld_c;
      tag_id_q[0] <= grant_id_c;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_p     = '0;
    if (tag_v_q[LAT-1]) begin
      rsp_valid[tag_id_q[LAT-1]] = 1'b1;
      rsp_p                      = mul_p;
    end
  end

`ifdef MUL_ARB_PERF_EN
  logic [31:0] issue_cnt_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      issue_cnt_q <= '0;
    end else if (grant_vld_c) begin
      issue_cnt_q <= issue_cnt_q + 32'd1;
    end
  end

  assign issue_cnt = issue_cnt_q;
`else
  assign issue_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized bench for mul_arbiter with a queue-free slot-based reference model and a latency-L multiplier model.
module tb_mul_arbiter;
  import flexka_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = FSIZE;
  localparam int unsigned PW = 2 * FSIZE;
  localparam int unsigned L  = MULTIPLIER_LATENCY;

  logic                  CLK = 1'b0;
  logic                  RSTN;
  logic [N-1:0]          req_valid;
  logic [N-1:0][W-1:0]   req_a;
  logic [N-1:0][W-1:0]   req_b;
  logic [N-1:0]          req_ready;
  logic [W-1:0]          mul_a;
  logic [W-1:0]          mul_b;
  logic [PW-1:0]         mul_p;
  logic [N-1:0]          rsp_valid;
  logic [PW-1:0]         rsp_p;
  logic [31:0]           issue_cnt;

  mul_arbiter #(.NUM_REQ(N)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_p(rsp_p), .issue_cnt(issue_cnt)
  );

  initial forever #5 CLK = ~CLK;

  // Multiplier stand-in: product visible L cycles after operands, never reset
  logic [PW-1:0] mul_pipe [L];
  assign mul_p = mul_pipe[L-1];
  always @(posedge CLK) begin
    mul_pipe[0] <= PW'(mul_a) * PW'(mul_b);
    for (int i = 1; i < L; i++) mul_pipe[i] <= mul_pipe[i-1];
  end

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model state: pointer, due-cycle slots for results, transfer count
  int            ptr = 0;
  bit            slot_v  [16];
  int            slot_id [16];
  logic [PW-1:0] slot_p  [16];
  logic [31:0]   cnt = '0;
  bit            g_v;
  int            g_id;
  logic [N-1:0]  e_ready, e_rv;
  logic [W-1:0]  e_a, e_b;
  logic [PW-1:0] e_p;

  always @(negedge CLK) begin
    g_v = 1'b0;
    g_id = 0;
    if (RSTN === 1'b1) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ptr + k) % N;
        if (!g_v && req_valid[idx]) begin
          g_v = 1'b1;
          g_id = idx;
        end
      end
    end
    e_ready = '0; e_a = '0; e_b = '0;
    if (g_v) begin
      e_ready[g_id] = 1'b1;
      e_a = req_a[g_id];
      e_b = req_b[g_id];
    end
    e_rv = '0; e_p = '0;
    if (RSTN === 1'b1 && slot_v[cyc % 16]) begin
      e_rv[slot_id[cyc % 16]] = 1'b1;
      e_p = slot_p[cyc % 16];
    end
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("mul_a", 64'(mul_a), 64'(e_a));
    chk("mul_b", 64'(mul_b), 64'(e_b));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("rsp_p", 64'(rsp_p), 64'(e_p));
`ifdef MUL_ARB_PERF_EN
    chk("issue_cnt", 64'(issue_cnt), 64'(cnt));
`else
    chk("issue_cnt", 64'(issue_cnt), 64'd0);
`endif
  end

  always @(posedge CLK) begin
    if (RSTN !== 1'b1) begin
      for (int s = 0; s < 16; s++) slot_v[s] = 1'b0;
      ptr = 0;
      cnt = '0;
    end else begin
      slot_v[cyc % 16] = 1'b0;
      if (g_v) begin
        slot_v[(cyc + L) % 16]  = 1'b1;
        slot_id[(cyc + L) % 16] = g_id;
        slot_p[(cyc + L) % 16]  = PW'(req_a[g_id]) * PW'(req_b[g_id]);
        ptr = (g_id + 1) % N;
        cnt = cnt + 32'd1;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i] = W'($urandom);
      req_b[i] = W'($urandom);
    end
  endtask

  initial begin
    RSTN = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) step();
    RSTN = 1'b1;

    // Single request in the very first cycle out of reset
    req_valid = 4'b0001;
    req_a[0] = W'(3);
    req_b[0] = W'(5);
    @(negedge CLK);
    chk("single_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    for (int d = 1; d <= L + 1; d++) begin
      @(negedge CLK);
      chk("single_rsp_valid", 64'(rsp_valid), (d == L) ? 64'h1 : 64'h0);
      if (d == L) chk("single_rsp_p", 64'(rsp_p), 64'd15);
      step();
    end

    // Four requesters held valid for eight cycles after a fresh reset
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
    for (int k = 0; k < 8 + L; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      rand_ops();
      @(negedge CLK);
      if (k < 8) chk("rr_grant", 64'(req_ready), 64'(1 << (k % 4)));
      if (k >= L) chk("rr_result", 64'(rsp_valid), 64'(1 << ((k - L) % 4)));
      step();
    end

    // Pointer moved to 2 by a lone req1, then req1+req3 contend
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1010;
    @(negedge CLK);
    chk("wrap_first", 64'(req_ready), 64'h8);
    step();
    @(negedge CLK);
    chk("wrap_second", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    repeat (L + 1) step();

    // Three issues, reset pulse, nothing in flight may surface
    req_valid = 4'hF;
    repeat (3) begin rand_ops(); step(); end
    req_valid = '0;
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
    for (int d = 0; d < L + 2; d++) begin
      @(negedge CLK);
      chk("post_reset_quiet", 64'(rsp_valid), 64'h0);
      step();
    end
    req_valid = 4'b0100;
    req_a[2] = W'(8'hFF);
    req_b[2] = W'(2);
    @(negedge CLK);
    chk("post_reset_grant", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    repeat (L - 1) step();
    @(negedge CLK);
    chk("post_reset_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("post_reset_rsp_p", 64'(rsp_p), 64'h1FE);
    step();

    // Ten transfers after reset for the counter
    RSTN = 1'b0;
    step();
    RSTN = 1'b1;
    req_valid = 4'b0001;
    repeat (10) begin rand_ops(); step(); end
    req_valid = '0;
    @(negedge CLK);
`ifdef MUL_ARB_PERF_EN
    chk("perf_ten", 64'(issue_cnt), 64'd10);
`else
    chk("perf_tied", 64'(issue_cnt), 64'd0);
`endif
    step();

    // Random traffic with occasional reset pulses
    for (int k = 0; k < 500; k++) begin
      req_valid = N'($urandom);
      rand_ops();
      RSTN = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      step();
    end
    RSTN = 1'b1;
    req_valid = '0;
    repeat (L + 2) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
